// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames WIDTH serial bits into a valid/ready parallel word.
// Optional SIPO_FRAME_PARITY_EN adds a trailing even-parity strobe per frame.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             si,
    input  logic             si_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_FRAME_PARITY_EN
    localparam int SW = WIDTH;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    // The final bit is taken straight from si, so only WIDTH-1 bits need storage.
    localparam int SW = WIDTH - 1;
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0] shreg;
    logic [SW:0] cat;
    logic [WIDTH-1:0] word;
    logic last, load, pe;
    assign cat = {si, shreg};
    assign last = si_valid && cnt == CNT_W'(WIDTH - 1);
`ifdef SIPO_FRAME_PARITY_EN
    assign word = shreg;
    assign pe = ^cat;
`else
    assign word = cat;
    assign pe = 1'b0;
`endif
    always_comb begin
        state_n = state;
        load = 1'b0;
        case (state)
            IDLE: if (start) state_n = SHIFT;
            SHIFT: if (last) begin
`ifdef SIPO_FRAME_PARITY_EN
                state_n = PARITY;
`else
                state_n = IDLE;
                load = 1'b1;
`endif
            end
`ifdef SIPO_FRAME_PARITY_EN
            PARITY: if (si_valid) begin
                state_n = IDLE;
                load = 1'b1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            cnt <= '0;
            shreg <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
            overrun <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state <= state_n;
            busy <= state_n != IDLE;
            if (state == IDLE && start) begin
                cnt <= '0;
                shreg <= '0;
            end else if (state == SHIFT && si_valid) begin
                cnt <= cnt + CNT_W'(1);
                shreg <= cat[SW:1];
            end
            // A pending word that is not being accepted blocks the new one.
            if (load && dout_valid && !dout_ready)
                overrun <= 1'b1;
            else if (load) begin
                dout <= word;
                dout_valid <= 1'b1;
                parity_err <= pe;
            end else if (dout_valid && dout_ready)
                dout_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed checks of framing, handshake, overrun and parity.
module tb_sipo_frame_ctrl;
    logic clk = 1'b0;
    logic rst_n, start, si, si_valid, dout_ready;
    logic [3:0] dout;
    logic dout_valid, busy, overrun, parity_err;
    int checks = 0;
    int errors = 0;

    sipo_frame_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .si(si), .si_valid(si_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        si = b;
        si_valid = 1'b1;
        tick();
        si_valid = 1'b0;
    endtask

    task automatic frame(input logic [3:0] b, input logic p);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) strobe(b[i]);
`ifdef SIPO_FRAME_PARITY_EN
        strobe(p);
`else
        si = p;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; si = 1'b0; si_valid = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_perr", parity_err, 0);

        start = 1'b1; tick(); start = 1'b0;
        strobe(1); strobe(0);
        check("mid_busy", busy, 1);
        do_reset();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_dout", dout, 0);
        frame(4'b1101, 1);
        check("basic_dout", dout, 4'hD);
        check("basic_valid", dout_valid, 1);
        check("basic_busy", busy, 0);
        check("basic_perr", parity_err, 0);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        check("accept_valid", dout_valid, 0);

        strobe(1);
        check("idle_ign_valid", dout_valid, 0);
        check("idle_ign_busy", busy, 0);

        start = 1'b1; tick(); start = 1'b0;
        strobe(1); strobe(0);
        for (int i = 0; i < 3; i++) begin
            si = i[0];
            tick();
            check("gap_busy", busy, 1);
        end
        strobe(1);
        check("gap_no_valid", dout_valid, 0);
        strobe(1);
`ifdef SIPO_FRAME_PARITY_EN
        strobe(1);
`endif
        check("gap_dout", dout, 4'hD);
        check("gap_valid", dout_valid, 1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;

        frame(4'b1101, 1);
        check("ovr_first_valid", dout_valid, 1);
        frame(4'b0100, 1);
        check("ovr_dout", dout, 4'hD);
        check("ovr_valid", dout_valid, 1);
        check("ovr_flag", overrun, 1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        check("ovr_accept_valid", dout_valid, 0);
        check("ovr_sticky", overrun, 1);

        do_reset();
        check("ovr_rst", overrun, 0);
        frame(4'b1101, 1);
        start = 1'b1; tick(); start = 1'b0;
        strobe(0); strobe(1); strobe(0);
`ifdef SIPO_FRAME_PARITY_EN
        strobe(0);
        dout_ready = 1'b1; strobe(1); dout_ready = 1'b0;
`else
        dout_ready = 1'b1; strobe(0); dout_ready = 1'b0;
`endif
        check("sim_dout", dout, 4'h2);
        check("sim_valid", dout_valid, 1);
        check("sim_overrun", overrun, 0);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;

`ifdef SIPO_FRAME_PARITY_EN
        start = 1'b1; tick(); start = 1'b0;
        strobe(1); strobe(0); strobe(1); strobe(1);
        check("par_wait_valid", dout_valid, 0);
        check("par_wait_busy", busy, 1);
        strobe(0);
        check("par_err_dout", dout, 4'hD);
        check("par_err_valid", dout_valid, 1);
        check("par_err", parity_err, 1);
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        frame(4'b1101, 1);
        check("par_ok", parity_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
